// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: access sizes, R_W sense, FSM states, bus owner.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // ST_FAULT is only reachable when the MOC timeout is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_align_chk.sv
// Checks that a data access size/address pair is naturally aligned and the size is not reserved.
// Latency: purely combinational.
// Backpressure: none.
module mem_align_chk
    import mem_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [1:0] size,
    output logic       legal
);

    // Bytes go anywhere, halfwords need addr[0]=0, words need addr[1:0]=00.
    always_comb begin
        legal = 1'b0;
        case (size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~addr[0];
            SZ_WORD: legal = (addr == 2'b00);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and data requesters onto one RAM port (MOV/R_W/MOC); MEM_TIMEOUT_EN adds a MOC timeout.
// Latency: MOV rises the cycle after a grant; ack (or err) pulses the cycle after MOC (or timeout).
// Backpressure: requesters hold req until ack/err; data beats fetch; BUS waits on MOC (bounded only with timeout).
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          MOV,
    output logic          R_W,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_size,
    output logic [DW-1:0] mem_wdata,
    input  logic          MOC,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Fetches are always word accesses, so the low two address bits are dropped on the way out.
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mem_access_ctrl: TIMEOUT must be at least 1");
    end

    state_t state;
    owner_t owner;
    logic   d_legal;

`ifdef MEM_TIMEOUT_EN
    // Counts completed BUS cycles without MOC; holds at most TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wait_cnt;
    logic          if_err_q;
    assign if_err = if_err_q;
`else
    assign if_err = 1'b0;
`endif

    mem_align_chk u_align_chk (
        .addr  (d_addr[1:0]),
        .size  (d_size),
        .legal (d_legal)
    );

    assign busy = (state != ST_IDLE);

    // Controller FSM: arbitration, RAM handshake, registered memory-side fields and requester pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            MOV       <= 1'b0;
            R_W       <= RW_READ;
            mem_addr  <= '0;
            mem_size  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            if_err_q  <= 1'b0;
`endif
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            if_err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (d_req) begin
                        if (d_legal) begin
                            owner     <= OWN_D;
                            mem_addr  <= d_addr;
                            mem_size  <= d_size;
                            mem_wdata <= d_wdata;
                            R_W       <= d_rw;
                            MOV       <= 1'b1;
                            state     <= ST_BUS;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end else begin
                            // Rejected data access also blocks fetch for this cycle.
                            d_err <= 1'b1;
                        end
                    end else if (if_req) begin
                        owner    <= OWN_IF;
                        mem_addr <= if_addr & WORD_MASK;
                        mem_size <= SZ_WORD;
                        R_W      <= RW_READ;
                        MOV      <= 1'b1;
                        state    <= ST_BUS;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ST_BUS: begin
                    if (MOC) begin
                        // Writes capture too; the requester ignores rdata on a store ack.
                        if (owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        MOV   <= 1'b0;
                        state <= ST_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        if (owner == OWN_D) begin
                            d_err <= 1'b1;
                        end else begin
                            if_err_q <= 1'b1;
                        end
                        MOV   <= 1'b0;
                        state <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                ST_FAULT: begin
                    state <= ST_IDLE;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed requester scenarios, a simple RAM responder and a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_ctrl;

    localparam int TB_TIMEOUT = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        MOV;
    logic        R_W;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        MOC = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // RAM responder configuration: MOC on the resp_n-th BUS cycle (0 = never).
    int          resp_n    = 1;
    logic [31:0] resp_data = 32'h0;
    bit          moc_force = 1'b0;
    int          bus_cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          cyc;
    } grant_t;
    grant_t grant_q[$];
    bit     mov_prev = 1'b0;
    int     mov_total = 0;
    int     derr_total = 0;

    mem_access_ctrl #(.AW(32), .DW(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .MOV       (MOV),
        .R_W       (R_W),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_wdata (mem_wdata),
        .MOC       (MOC),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM side: counts BUS cycles and answers with MOC on the configured one.
    always @(negedge clk) begin
        if (MOV) bus_cyc = bus_cyc + 1;
        else     bus_cyc = 0;
        MOC       = moc_force || (MOV && (resp_n != 0) && (bus_cyc == resp_n));
        mem_rdata = resp_data;
    end

    // Record each new bus grant as seen on the memory side.
    always @(negedge clk) begin
        if (MOV && !mov_prev) begin
            grant_q.push_back('{addr: mem_addr, rw: R_W, size: mem_size, wdata: mem_wdata, cyc: cyc});
        end
        if (MOV)   mov_total  = mov_total + 1;
        if (d_err) derr_total = derr_total + 1;
        mov_prev = MOV;
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_live = 0, m_inflight = 0, m_cool = 0, m_owner_d = 0;
    logic        m_rw = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rd_if = '0, m_rd_d = '0;
    logic [1:0]  m_size = '0;
    int          m_wait = 0;

    initial begin : compare_proc
        bit          s_clr, s_if_req, s_d_req, s_d_rw, s_moc;
        logic [1:0]  s_d_size;
        logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_mrd;
        bit          e_if_ack, e_d_ack, e_d_err, e_if_err, legal;
        forever begin
            @(posedge clk);
            s_clr = clr; s_if_req = if_req; s_if_addr = if_addr;
            s_d_req = d_req; s_d_rw = d_rw; s_d_size = d_size; s_d_addr = d_addr; s_d_wdata = d_wdata;
            s_moc = MOC; s_mrd = mem_rdata;
            #1;
            e_if_ack = 0; e_d_ack = 0; e_d_err = 0; e_if_err = 0;
            if (s_clr) begin
                m_live = 1; m_inflight = 0; m_cool = 0; m_rw = 1'b1;
                m_addr = '0; m_size = '0; m_wdata = '0; m_rd_if = '0; m_rd_d = '0;
            end else if (m_cool) begin
                m_cool = 0;
            end else if (m_inflight) begin
                if (s_moc) begin
                    m_inflight = 0; m_cool = 1;
                    if (m_owner_d) begin m_rd_d = s_mrd; e_d_ack = 1; end
                    else begin m_rd_if = s_mrd; e_if_ack = 1; end
                end else if (TO_EN && (m_wait + 1 == TB_TIMEOUT)) begin
                    m_inflight = 0; m_cool = 1;
                    if (m_owner_d) e_d_err = 1; else e_if_err = 1;
                end else begin
                    m_wait++;
                end
            end else if (s_d_req) begin
                legal = (s_d_size == 2'd0) ||
                        (s_d_size == 2'd1 && (s_d_addr % 2) == 0) ||
                        (s_d_size == 2'd2 && (s_d_addr % 4) == 0);
                if (legal) begin
                    m_inflight = 1; m_owner_d = 1; m_wait = 0;
                    m_addr = s_d_addr; m_size = s_d_size; m_wdata = s_d_wdata; m_rw = s_d_rw;
                end else begin
                    e_d_err = 1;
                end
            end else if (s_if_req) begin
                m_inflight = 1; m_owner_d = 0; m_wait = 0;
                m_addr = s_if_addr - (s_if_addr % 4); m_size = 2'd2; m_rw = 1'b1;
            end
            if (m_live) begin
                check("cmp_MOV",      32'(MOV),    32'(m_inflight));
                check("cmp_busy",     32'(busy),   32'(m_inflight || m_cool));
                check("cmp_if_ack",   32'(if_ack), 32'(e_if_ack));
                check("cmp_d_ack",    32'(d_ack),  32'(e_d_ack));
                check("cmp_d_err",    32'(d_err),  32'(e_d_err));
                check("cmp_if_err",   32'(if_err), 32'(e_if_err));
                check("cmp_R_W",      32'(R_W),    32'(m_rw));
                check("cmp_mem_addr", mem_addr,    m_addr);
                if (m_inflight) check("cmp_mem_size", 32'(mem_size), 32'(m_size));
                if (m_inflight && !m_rw) check("cmp_mem_wdata", mem_wdata, m_wdata);
                if (e_d_ack && m_rw) check("cmp_d_rdata", d_rdata, m_rd_d);
                if (e_if_ack) check("cmp_if_rdata", if_rdata, m_rd_if);
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic d_access(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, output int t_req, output int t_done, output bit got_err);
        @(negedge clk);
        d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
        t_req = cyc; t_done = -1; got_err = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d_ack || d_err) begin
                got_err = d_err; t_done = cyc; d_req = 1'b0;
                break;
            end
        end
        d_req = 1'b0;
        check("d_req_answered", 32'(t_done >= 0), 32'd1);
    endtask

    task automatic if_access(input logic [31:0] a, output int t_req, output int t_done);
        @(negedge clk);
        if_addr = a; if_req = 1'b1;
        t_req = cyc; t_done = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if_ack || if_err) begin
                t_done = cyc; if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0;
        check("if_req_answered", 32'(t_done >= 0), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          bad;
    } dvec_t;

    initial begin : stimulus
        int tq, td, tq2, td2, mv0, de0;
        bit er;
        grant_t g;
        dvec_t vecs[5];

        clr = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_rw = 1'b1; d_size = 2'b10; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        // Reset state
        check("rst_MOV",      32'(MOV),      32'd0);
        check("rst_R_W",      32'(R_W),      32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_mem_addr", mem_addr,      32'd0);
        check("rst_mem_size", 32'(mem_size), 32'd0);
        check("rst_d_rdata",  d_rdata,       32'd0);
        check("rst_if_rdata", if_rdata,      32'd0);
        @(negedge clk);

        // D word read at 0x10, MOC on the 3rd BUS cycle
        resp_n = 3; resp_data = 32'hDEADBEEF; grant_q.delete();
        d_access(1'b1, 2'b10, 32'h10, 32'h0, tq, td, er);
        check("dread_latency", td - tq, 32'd4);
        check("dread_err",     32'(er), 32'd0);
        check("dread_rdata",   d_rdata, 32'hDEADBEEF);
        check("dread_grants",  grant_q.size(), 32'd1);
        if (grant_q.size() > 0) begin
            g = grant_q.pop_front();
            check("dread_addr", g.addr, 32'h10);
            check("dread_rw",   32'(g.rw), 32'd1);
            check("dread_size", 32'(g.size), 32'd2);
        end
        @(negedge clk);

        // Fetch 0x106 -> word 0x104, MOC in the first BUS cycle
        resp_n = 1; resp_data = 32'hE59F1004; grant_q.delete();
        if_access(32'h0000_0106, tq, td);
        check("fetch_latency", td - tq, 32'd2);
        check("fetch_rdata",   if_rdata, 32'hE59F1004);
        if (grant_q.size() > 0) begin
            g = grant_q.pop_front();
            check("fetch_addr", g.addr, 32'h0000_0104);
            check("fetch_size", 32'(g.size), 32'd2);
        end else check("fetch_grants", 32'd0, 32'd1);
        @(negedge clk);

        // Contention: D byte write 0x55 @0x21 vs fetch @0x203
        resp_n = 1; resp_data = 32'h0BAD_0BAD; grant_q.delete();
        fork
            d_access(1'b0, 2'b00, 32'h21, 32'h55, tq, td, er);
            if_access(32'h0000_0203, tq2, td2);
        join
        check("cont_d_latency",  td - tq,   32'd2);
        check("cont_if_latency", td2 - tq2, 32'd5);
        check("cont_grants",     grant_q.size(), 32'd2);
        if (grant_q.size() == 2) begin
            g = grant_q.pop_front();
            check("cont_d_rw",    32'(g.rw), 32'd0);
            check("cont_d_addr",  g.addr,    32'h21);
            check("cont_d_wdata", g.wdata,   32'h55);
            check("cont_d_size",  32'(g.size), 32'd0);
            g = grant_q.pop_front();
            check("cont_if_addr", g.addr,    32'h200);
            check("cont_if_cyc",  g.cyc - tq2, 32'd4);
        end
        @(negedge clk);

        // Misaligned halfword @0x03 with a concurrent fetch @0x40
        resp_n = 1; resp_data = 32'h1111_2222; grant_q.delete(); mv0 = mov_total;
        fork
            d_access(1'b1, 2'b01, 32'h03, 32'h0, tq, td, er);
            if_access(32'h40, tq2, td2);
        join
        check("mis_err",        32'(er),   32'd1);
        check("mis_err_cyc",    td - tq,   32'd1);
        check("mis_if_latency", td2 - tq2, 32'd3);
        check("mis_grants",     grant_q.size(), 32'd1);
        if (grant_q.size() > 0) begin
            g = grant_q.pop_front();
            check("mis_grant_addr", g.addr, 32'h40);
            check("mis_grant_rw",   32'(g.rw), 32'd1);
        end
        check("mis_mov_cycles", mov_total - mv0, 32'd1);
        @(negedge clk);

        // Alignment table
        vecs[0] = '{rw: 1'b0, sz: 2'b01, addr: 32'h22, wd: 32'h1234ABCD, bad: 1'b0};
        vecs[1] = '{rw: 1'b1, sz: 2'b00, addr: 32'h03, wd: 32'h0,        bad: 1'b0};
        vecs[2] = '{rw: 1'b1, sz: 2'b10, addr: 32'h02, wd: 32'h0,        bad: 1'b1};
        vecs[3] = '{rw: 1'b0, sz: 2'b11, addr: 32'h08, wd: 32'h0,        bad: 1'b1};
        vecs[4] = '{rw: 1'b1, sz: 2'b01, addr: 32'h05, wd: 32'h0,        bad: 1'b1};
        resp_n = 2; resp_data = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            grant_q.delete();
            d_access(vecs[i].rw, vecs[i].sz, vecs[i].addr, vecs[i].wd, tq, td, er);
            check("tbl_err",     32'(er), 32'(vecs[i].bad));
            check("tbl_latency", td - tq, vecs[i].bad ? 32'd1 : 32'd3);
            check("tbl_grants",  grant_q.size(), vecs[i].bad ? 32'd0 : 32'd1);
            if (grant_q.size() > 0) begin
                g = grant_q.pop_front();
                check("tbl_addr", g.addr, vecs[i].addr);
            end
            @(negedge clk);
        end

        // Reset mid-access, then a stray MOC while idle
        resp_n = 0; grant_q.delete();
        @(negedge clk);
        d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h80; d_req = 1'b1;
        @(negedge clk);
        check("rstmid_mov_before", 32'(MOV), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        check("rstmid_mov",   32'(MOV),   32'd0);
        check("rstmid_busy",  32'(busy),  32'd0);
        check("rstmid_d_ack", 32'(d_ack), 32'd0);
        check("rstmid_addr",  mem_addr,   32'd0);
        clr = 1'b0; d_req = 1'b0; moc_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_moc_mov",   32'(MOV),   32'd0);
            check("late_moc_d_ack", 32'(d_ack), 32'd0);
        end
        moc_force = 1'b0;
        repeat (2) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // MOC never comes: bus released after TIMEOUT cycles with one d_err
        resp_n = 0; mv0 = mov_total; de0 = derr_total;
        d_access(1'b1, 2'b10, 32'h44, 32'h0, tq, td, er);
        check("to_err",        32'(er), 32'd1);
        check("to_latency",    td - tq, 32'd5);
        @(negedge clk);
        check("to_mov_cycles", mov_total - mv0, 32'd4);
        check("to_err_pulses", derr_total - de0, 32'd1);
        check("to_busy",       32'(busy), 32'd0);
`else
        // MOC never comes: bus waits indefinitely until reset
        resp_n = 0; de0 = derr_total;
        @(negedge clk);
        d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h44; d_req = 1'b1;
        repeat (20) @(negedge clk);
        check("wait_mov",  32'(MOV),  32'd1);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_no_err", derr_total - de0, 32'd0);
        clr = 1'b1; d_req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        check("wait_cleared", 32'(busy), 32'd0);
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
